// File: rtl/button_event_gen.sv
// Button event generator: turns a debounced, clk-synchronous button level into
// press / release / long-press / auto-repeat pulses plus a held flag and press counter.
module button_event_gen #(
  parameter int CNT_W      = 24,
  parameter int LONG_CNT   = 5_000_000,
  parameter int REPEAT_CNT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_level,
  input  logic       enable,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESSED      = 2'd1,
    ST_LONG_HELD    = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             prev_r;
  logic             rise_s;

  // prev_r resets to 1 so a button held through reset never counts as a rise
  assign rise_s = btn_level & ~prev_r;

  // Press-tracking FSM with registered pulse, held and counter outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      prev_r        <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      prev_r        <= btn_level;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rise_s && enable) begin
            state_r     <= ST_PRESSED;
            cnt_r       <= CNT_ZERO;
            press_pulse <= 1'b1;
            held        <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            cnt_r <= CNT_ZERO;
            held  <= 1'b0;
          end
        end
        // Release outranks disable, which outranks long/repeat timing
        ST_PRESSED: begin
          if (!btn_level) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (!enable) begin
            state_r <= ST_WAIT_RELEASE;
            cnt_r   <= CNT_ZERO;
            held    <= 1'b0;
          end else if (cnt_r == LONG_LAST) begin
            state_r    <= ST_LONG_HELD;
            cnt_r      <= CNT_ZERO;
            long_pulse <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_LONG_HELD: begin
          if (!btn_level) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (!enable) begin
            state_r <= ST_WAIT_RELEASE;
            cnt_r   <= CNT_ZERO;
            held    <= 1'b0;
          end else if (cnt_r == REPEAT_LAST) begin
            cnt_r        <= CNT_ZERO;
            repeat_pulse <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!btn_level) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_RELEASE;
          end
          cnt_r <= CNT_ZERO;
          held  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          held    <= 1'b0;
        end
      endcase
    end
  end

endmodule
